spi_shifter: RTL and testbench

- Hardware SPI master engine for the two SD-card slots; replaces bit-banged SCLK/MOSI toggling with a byte-wide shifter.
- Sits directly downstream of the CPLD bus-decode stage: decode produces a one-cycle write strobe plus data byte and a latched divider value; this block drives SCLK/MOSI, samples MISO and returns the received byte and status.
- Card selects (nSD0/nSD1) stay in the decode stage; this block only shifts, SPI mode 0, MSB first.

---
 rtl/kolibri_pkg.sv | 18 +
 rtl/spi_shifter_if.sv | 27 ++
 rtl/spi_halfper.sv | 30 +++
 rtl/spi_shifter.sv | 133 +++++++++++++
 tb/tb_spi_shifter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/kolibri_pkg.sv
// Shared definitions for the kolibri CPLD SPI engine.
//   spiState_t    : shifter FSM state encoding (IDLE / LOW / HIGH)
//   SPI_DATA_ADDR : CPU address of the SPI data register
//   SPI_DIV_ADDR  : CPU address of the SPI divider register
//   SD_INIT_DIV   : divider giving 400 kHz SCLK from 48 MHz (SD init)
//   RDATA_RST     : received-byte value after reset
package kolibri_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spiState_t;

    localparam logic [15:0] SPI_DATA_ADDR = 16'hFE31;
    localparam logic [15:0] SPI_DIV_ADDR  = 16'hFE33;
    localparam int          SD_INIT_DIV   = 59;
    localparam logic [7:0]  RDATA_RST     = 8'hFF;
endpackage

// File: rtl/spi_shifter_if.sv
// Bus between the decode stage / SD slot and the SPI shifter.
//   master : decode side (drives WSTB/WDATA/CLKDIV, card drives MISO)
//   slave  : shifter side (drives SCLK/MOSI/RDATA/BUSY/DONE/OVR)
interface spi_shifter_if #(
    parameter int DIVW = 8
);
    logic            WSTB;
    logic [7:0]      WDATA;
    logic [DIVW-1:0] CLKDIV;
    logic            MISO;
    logic            SCLK;
    logic            MOSI;
    logic [7:0]      RDATA;
    logic            BUSY;
    logic            DONE;
    logic            OVR;

    modport master (
        output WSTB, WDATA, CLKDIV, MISO,
        input  SCLK, MOSI, RDATA, BUSY, DONE, OVR
    );

    modport slave (
        input  WSTB, WDATA, CLKDIV, MISO,
        output SCLK, MOSI, RDATA, BUSY, DONE, OVR
    );
endinterface

// File: rtl/spi_halfper.sv
// Loadable half-period down-counter for the SPI shifter.
//   MHZ48   : master clock
//   RES     : asynchronous active-high reset (count cleared)
//   load    : load loadVal on the next edge (wins over decrement)
//   loadVal : value to load
//   tc      : terminal count, high while the count is zero
// The count parks at zero, so nothing needs to stop it while idle.
module spi_halfper #(
    parameter int DIVW = 8
) (
    input  logic            MHZ48,
    input  logic            RES,
    input  logic            load,
    input  logic [DIVW-1:0] loadVal,
    output logic            tc
);
    logic [DIVW-1:0] cnt;

    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (cnt != '0) begin
            cnt <= cnt - DIVW'(1);
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/spi_shifter.sv
// Byte-wide SPI master (mode 0, MSB first) for the SD-card slots.
//   MHZ48 : master clock, all state changes on its rising edge
//   RES   : asynchronous active-high reset
//   bus   : slave side of spi_shifter_if
//           WSTB/WDATA start a byte, CLKDIV sets half-period (CLKDIV+1),
//           SCLK/MOSI/MISO are the serial pins, RDATA is the last byte
//           received, BUSY/DONE/OVR are status.
//
// state | meaning
// IDLE  | no transfer, SCLK low, MOSI at IDLE_MOSI
// LOW   | SCLK low phase, MOSI holds current bit
// HIGH  | SCLK high phase, bit already sampled on the rising edge
module spi_shifter
    import kolibri_pkg::*;
#(
    parameter int   DIVW      = 8,
    parameter logic IDLE_MOSI = 1'b1
) (
    input logic            MHZ48,
    input logic            RES,
    spi_shifter_if.slave   bus
);
    spiState_t       state, stateNext;
    logic [7:0]      tx, rx, rdataQ;
    logic [2:0]      bitCnt;
    logic [DIVW-1:0] div, cntVal;
    logic            cntLoad, tc;
    logic            sclkQ, mosiQ, busyQ, doneQ, ovrQ;
    logic            accept, rise, fall, lastBit;

    spi_halfper #(.DIVW(DIVW)) uHalfper (
        .MHZ48   (MHZ48),
        .RES     (RES),
        .load    (cntLoad),
        .loadVal (cntVal),
        .tc      (tc)
    );

    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        cntLoad   = 1'b0;
        cntVal    = div;
        accept    = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        lastBit   = (bitCnt == 3'd7);
        case (state)
            IDLE: begin
                if (bus.WSTB) begin
                    accept    = 1'b1;
                    stateNext = LOW;
                    cntLoad   = 1'b1;
                    cntVal    = bus.CLKDIV;
                end
            end
            LOW: begin
                if (tc) begin
                    rise      = 1'b1;
                    stateNext = HIGH;
                    cntLoad   = 1'b1;
                end
            end
            HIGH: begin
                if (tc) begin
                    fall = 1'b1;
                    if (lastBit) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext = LOW;
                        cntLoad   = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            tx     <= '0;
            rx     <= '0;
            bitCnt <= '0;
            div    <= '0;
            rdataQ <= RDATA_RST;
            sclkQ  <= 1'b0;
            mosiQ  <= IDLE_MOSI;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            ovrQ   <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (accept) begin
                tx     <= bus.WDATA;
                mosiQ  <= bus.WDATA[7];
                bitCnt <= '0;
                div    <= bus.CLKDIV;
                busyQ  <= 1'b1;
                ovrQ   <= 1'b0;
            end else if (bus.WSTB) begin
                // Any strobe outside IDLE, including the completing edge.
                ovrQ <= 1'b1;
            end
            if (rise) begin
                sclkQ <= 1'b1;
                rx    <= {rx[6:0], bus.MISO};
            end
            if (fall) begin
                sclkQ <= 1'b0;
                if (lastBit) begin
                    rdataQ <= rx;
                    busyQ  <= 1'b0;
                    doneQ  <= 1'b1;
                    mosiQ  <= IDLE_MOSI;
                end else begin
                    bitCnt <= bitCnt + 3'd1;
                    mosiQ  <= tx[3'd6 - bitCnt];
                end
            end
        end
    end

    assign bus.SCLK  = sclkQ;
    assign bus.MOSI  = mosiQ;
    assign bus.RDATA = rdataQ;
    assign bus.BUSY  = busyQ;
    assign bus.DONE  = doneQ;
    assign bus.OVR   = ovrQ;
endmodule

// File: tb/tb_spi_shifter.sv
module tb_spi_shifter;
    import kolibri_pkg::*;

    localparam int DIVW = 8;

    logic clk = 1'b0;
    logic rst;
    logic loopback;
    logic misoBit;
    logic [7:0] prevRx;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_shifter_if #(.DIVW(DIVW)) ifc ();

    assign ifc.MISO = loopback ? ifc.MOSI : misoBit;

    spi_shifter #(.DIVW(DIVW), .IDLE_MOSI(1'b1)) dut (
        .MHZ48 (clk),
        .RES   (rst),
        .bus   (ifc)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idleChk(input int n);
        int quietBad;
        quietBad = 0;
        repeat (n) begin
            @(negedge clk);
            if (ifc.DONE !== 1'b0 || ifc.BUSY !== 1'b0) quietBad++;
        end
        checkVal("idle_quiet", quietBad, 0);
    endtask

    // Called at a negedge. Runs one byte and checks it against what an SPI
    // mode-0 transfer of w at half-period d+1 must look like on the pins.
    task automatic runByte(input logic [7:0] w, input int d, input logic [7:0] r,
                           input bit loop, input int ovrAt, input int newDiv);
        int c, rises, firstRise, lastToggle, len, phMin, phMax, doneCnt, rdBad, misoIdx;
        logic [7:0] mosiByte, expRx;
        logic prevSclk;
        loopback   = loop;
        misoIdx    = 7;
        misoBit    = r[7];
        expRx      = loop ? w : r;
        ifc.CLKDIV = DIVW'(d);
        ifc.WDATA  = w;
        ifc.WSTB   = 1'b1;
        @(negedge clk);
        ifc.WSTB   = 1'b0;
        ifc.WDATA  = 8'($urandom);
        c = 0; rises = 0; firstRise = -1; lastToggle = 1;
        phMin = 1000000; phMax = 0; doneCnt = 0; rdBad = 0;
        mosiByte = '0; prevSclk = 1'b0;
        while (ifc.BUSY === 1'b1 && c < 20000) begin
            c++;
            if (ifc.DONE !== 1'b0) doneCnt++;
            if (ifc.RDATA !== prevRx) rdBad++;
            if (ifc.SCLK !== prevSclk) begin
                len = c - lastToggle;
                lastToggle = c;
                if (len < phMin) phMin = len;
                if (len > phMax) phMax = len;
                if (ifc.SCLK === 1'b1) begin
                    rises++;
                    if (rises == 1) firstRise = c - 1;
                    mosiByte = {mosiByte[6:0], ifc.MOSI};
                end else begin
                    misoIdx--;
                    if (misoIdx >= 0) misoBit = r[misoIdx];
                end
                prevSclk = ifc.SCLK;
            end
            if (c == ovrAt) begin
                ifc.WSTB  = 1'b1;
                ifc.WDATA = w ^ 8'h5A;
            end
            if (c == 5 && newDiv >= 0) ifc.CLKDIV = DIVW'(newDiv);
            @(negedge clk);
            ifc.WSTB = 1'b0;
        end
        if (prevSclk === 1'b1) begin
            len = c + 1 - lastToggle;
            if (len < phMin) phMin = len;
            if (len > phMax) phMax = len;
        end
        checkVal("busy_cycles", c, 16 * (d + 1));
        checkVal("sclk_rises", rises, 8);
        checkVal("first_rise", firstRise, d + 1);
        checkVal("phase_min", phMin, d + 1);
        checkVal("phase_max", phMax, d + 1);
        checkVal("mosi_byte", mosiByte, w);
        checkVal("done_early", doneCnt, 0);
        checkVal("done_end", ifc.DONE, 1);
        checkVal("sclk_end", ifc.SCLK, 0);
        checkVal("mosi_idle", ifc.MOSI, 1);
        checkVal("rdata_stable", rdBad, 0);
        checkVal("rdata", ifc.RDATA, expRx);
        checkVal("ovr", ifc.OVR, (ovrAt != 0) ? 1 : 0);
        prevRx = expRx;
    endtask

    initial begin
        int d, quietBad;
        rst        = 1'b1;
        loopback   = 1'b0;
        misoBit    = 1'b1;
        prevRx     = RDATA_RST;
        ifc.WSTB   = 1'b0;
        ifc.WDATA  = '0;
        ifc.CLKDIV = '0;
        #2;
        checkVal("rst_sclk", ifc.SCLK, 0);
        checkVal("rst_mosi", ifc.MOSI, 1);
        checkVal("rst_busy", ifc.BUSY, 0);
        checkVal("rst_done", ifc.DONE, 0);
        checkVal("rst_ovr", ifc.OVR, 0);
        checkVal("rst_rdata", ifc.RDATA, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        idleChk(3);

        runByte(8'hA5, 0, 8'h00, 1'b1, 0, -1);
        idleChk(2);
        runByte(8'hFF, SD_INIT_DIV, 8'h3C, 1'b0, 0, -1);
        idleChk(2);

        runByte(8'h12, 2, 8'hC3, 1'b0, 5, -1);
        idleChk(1);
        runByte(8'h9E, 0, 8'h71, 1'b0, 0, -1);
        idleChk(1);

        runByte(8'h6B, 1, 8'h2D, 1'b0, 0, 9);
        idleChk(1);
        runByte(8'hD4, 9, 8'hB8, 1'b0, 0, -1);
        idleChk(1);

        runByte(8'h81, 1, 8'h5E, 1'b0, 0, -1);
        runByte(8'h7E, 1, 8'hA1, 1'b0, 0, -1);
        idleChk(1);

        // completing-cycle strobe must be dropped and flagged
        runByte(8'h3A, 1, 8'h44, 1'b0, 32, -1);
        idleChk(1);

        for (int i = 0; i < 20; i++) begin
            d = int'($urandom_range(0, 7));
            runByte(8'($urandom), d, 8'($urandom), 1'($urandom),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16 * (d + 1))) : 0,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1);
            if ($urandom_range(0, 1) == 1) idleChk(int'($urandom_range(1, 4)));
        end
        idleChk(1);

        // reset in the middle of a byte
        loopback   = 1'b0;
        misoBit    = 1'b0;
        ifc.CLKDIV = DIVW'(3);
        ifc.WDATA  = 8'hA5;
        ifc.WSTB   = 1'b1;
        @(negedge clk);
        ifc.WSTB = 1'b0;
        repeat (20) @(negedge clk);
        checkVal("mid_busy", ifc.BUSY, 1);
        rst = 1'b1;
        #1;
        checkVal("mrst_sclk", ifc.SCLK, 0);
        checkVal("mrst_mosi", ifc.MOSI, 1);
        checkVal("mrst_busy", ifc.BUSY, 0);
        checkVal("mrst_rdata", ifc.RDATA, 8'hFF);
        checkVal("mrst_done", ifc.DONE, 0);
        @(negedge clk);
        rst = 1'b0;
        prevRx = RDATA_RST;
        quietBad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifc.DONE !== 1'b0 || ifc.BUSY !== 1'b0 || ifc.SCLK !== 1'b0) quietBad++;
        end
        checkVal("post_rst_quiet", quietBad, 0);
        checkVal("post_rst_rdata", ifc.RDATA, 8'hFF);
        runByte(8'hC9, 2, 8'h36, 1'b0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
